std_win_acc: RTL and testbench



---
 rtl/std_win_acc.sv | 147 ++++++++++++++
 tb/tb_std_win_acc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/std_win_acc.sv
// Windowed signed accumulator: sums COUNT sign-extended samples per window and
// publishes the sum with a one-cycle done pulse. Define STD_WIN_ACC_SAT_EN for saturating adds.
module std_win_acc #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 40,
    parameter int COUNT     = 8,
    parameter int CNT_W     = $clog2(COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic                 write_en,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 done,
    output logic                 busy,
    output logic [CNT_W-1:0]     count,
    output logic                 sat
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ACC_WIDTH-1:0] out_q, out_d;
    logic                 done_q, done_d;
    logic                 sat_q, sat_d;
    logic                 sticky_q, sticky_d;

    logic [ACC_WIDTH-1:0] sext_s;
    logic [ACC_WIDTH-1:0] base_s;
    logic [ACC_WIDTH-1:0] sum_s;
    logic                 clip_s;
    logic                 last_s;
    logic                 sticky_new_s;

    assign sext_s = ACC_WIDTH'($signed(in));

    // Addend base: a fresh window starts from zero regardless of acc contents.
    always_comb begin
        base_s = {ACC_WIDTH{1'b0}};
        case (state_q)
            S_IDLE:  base_s = {ACC_WIDTH{1'b0}};
            S_ACC:   base_s = acc_q;
            default: base_s = {ACC_WIDTH{1'b0}};
        endcase
    end

`ifdef STD_WIN_ACC_SAT_EN
    // Returns {clipped, result}; overflow only possible when operand signs agree.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a_v,
                                                   input logic [ACC_WIDTH-1:0] b_v);
        logic [ACC_WIDTH-1:0] s_v;
        logic                 ovf_v;
        s_v   = a_v + b_v;
        ovf_v = (a_v[ACC_WIDTH-1] == b_v[ACC_WIDTH-1]) &&
                (s_v[ACC_WIDTH-1] != a_v[ACC_WIDTH-1]);
        if (ovf_v) begin
            if (a_v[ACC_WIDTH-1]) begin
                s_v = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                s_v = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            s_v = a_v + b_v;
        end
        return {ovf_v, s_v};
    endfunction

    assign {clip_s, sum_s} = sat_add(base_s, sext_s);
`else
    assign sum_s  = base_s + sext_s;
    assign clip_s = 1'b0;
`endif

    assign last_s       = (count_q == CNT_W'(COUNT - 1));
    assign sticky_new_s = ((state_q == S_ACC) ? sticky_q : 1'b0) | clip_s;

    // Next-state logic: clear beats write_en; the COUNT-th sample publishes the window.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        out_d    = out_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        sticky_d = sticky_q;
        if (clear) begin
            state_d  = S_IDLE;
            acc_d    = {ACC_WIDTH{1'b0}};
            count_d  = {CNT_W{1'b0}};
            sticky_d = 1'b0;
        end else if (write_en) begin
            if (last_s) begin
                out_d    = sum_s;
                sat_d    = sticky_new_s;
                done_d   = 1'b1;
                state_d  = S_IDLE;
                acc_d    = {ACC_WIDTH{1'b0}};
                count_d  = {CNT_W{1'b0}};
                sticky_d = 1'b0;
            end else begin
                state_d  = S_ACC;
                acc_d    = sum_s;
                count_d  = count_q + CNT_W'(1);
                sticky_d = sticky_new_s;
            end
        end else begin
            state_d  = state_q;
            acc_d    = acc_q;
            count_d  = count_q;
            sticky_d = sticky_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= {ACC_WIDTH{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            out_q    <= {ACC_WIDTH{1'b0}};
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            out_q    <= out_d;
            done_q   <= done_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
        end
    end

    assign out   = out_q;
    assign done  = done_q;
    assign busy  = (state_q == S_ACC);
    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_std_win_acc.sv
// Randomized bench for std_win_acc: three configurations checked against an
// arithmetic window model every cycle, plus literal expectations from the test plan.
module tb_std_win_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic        clear;
    logic [31:0] din;
    bit          chk_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [39:0] a_out;  logic a_done, a_busy, a_sat;  logic [2:0] a_count;
    logic [31:0] b_out;  logic b_done, b_busy, b_sat;  logic [2:0] b_count;
    logic [39:0] c_out;  logic c_done, c_busy, c_sat;  logic [0:0] c_count;

    always #5 clk = ~clk;

    std_win_acc #(.WIDTH(32), .ACC_WIDTH(40), .COUNT(4)) u_a (
        .clk(clk), .reset(reset), .in(din), .write_en(write_en), .clear(clear),
        .out(a_out), .done(a_done), .busy(a_busy), .count(a_count), .sat(a_sat));
    std_win_acc #(.WIDTH(32), .ACC_WIDTH(32), .COUNT(4)) u_b (
        .clk(clk), .reset(reset), .in(din), .write_en(write_en), .clear(clear),
        .out(b_out), .done(b_done), .busy(b_busy), .count(b_count), .sat(b_sat));
    std_win_acc #(.WIDTH(32), .ACC_WIDTH(40), .COUNT(1)) u_c (
        .clk(clk), .reset(reset), .in(din), .write_en(write_en), .clear(clear),
        .out(c_out), .done(c_done), .busy(c_busy), .count(c_count), .sat(c_sat));

    // Window model: signed values held as longint, one entry per instance.
    int     p_cnt [3] = '{4, 4, 1};
    int     p_aw  [3] = '{40, 32, 40};
    longint m_acc [3];
    longint m_out [3];
    int     m_cnt [3];
    bit     m_sat [3];
    bit     m_done[3];
    bit     m_stk [3];

    function automatic longint wrapv(longint x, int aw);
        longint m, r;
        m = longint'(1) << aw;
        r = x & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_out[i] = 0; m_cnt[i] = 0;
            m_sat[i] = 1'b0; m_done[i] = 1'b0; m_stk[i] = 1'b0;
        end
    endtask

    task automatic model_step(bit we, bit clr, logic [31:0] d);
        for (int i = 0; i < 3; i++) begin
            longint s, mx, mn;
            bit     clip, stk;
            m_done[i] = 1'b0;
            if (clr) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_stk[i] = 1'b0;
            end else if (we) begin
                mx   = (longint'(1) << (p_aw[i] - 1)) - 1;
                mn   = -(longint'(1) << (p_aw[i] - 1));
                s    = ((m_cnt[i] == 0) ? 64'sd0 : m_acc[i]) + longint'($signed(d));
                clip = 1'b0;
`ifdef STD_WIN_ACC_SAT_EN
                if (s > mx) begin s = mx; clip = 1'b1; end
                else if (s < mn) begin s = mn; clip = 1'b1; end
`else
                s = wrapv(s, p_aw[i]);
`endif
                stk = ((m_cnt[i] == 0) ? 1'b0 : m_stk[i]) | clip;
                if (m_cnt[i] + 1 == p_cnt[i]) begin
                    m_out[i] = s; m_sat[i] = stk; m_done[i] = 1'b1;
                    m_acc[i] = 0; m_cnt[i] = 0; m_stk[i] = 1'b0;
                end else begin
                    m_acc[i] = s; m_cnt[i] = m_cnt[i] + 1; m_stk[i] = stk;
                end
            end
        end
    endtask

    task automatic chk(string nm, longint got, longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Per-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("a.out",   longint'($signed(a_out)), m_out[0]);
            chk("a.done",  longint'(a_done), longint'(m_done[0]));
            chk("a.busy",  longint'(a_busy), longint'(m_cnt[0] != 0));
            chk("a.count", longint'(a_count), longint'(m_cnt[0]));
            chk("a.sat",   longint'(a_sat), longint'(m_sat[0]));
            chk("b.out",   longint'($signed(b_out)), m_out[1]);
            chk("b.done",  longint'(b_done), longint'(m_done[1]));
            chk("b.busy",  longint'(b_busy), longint'(m_cnt[1] != 0));
            chk("b.count", longint'(b_count), longint'(m_cnt[1]));
            chk("b.sat",   longint'(b_sat), longint'(m_sat[1]));
            chk("c.out",   longint'($signed(c_out)), m_out[2]);
            chk("c.done",  longint'(c_done), longint'(m_done[2]));
            chk("c.busy",  longint'(c_busy), longint'(m_cnt[2] != 0));
            chk("c.count", longint'(c_count), longint'(m_cnt[2]));
            chk("c.sat",   longint'(c_sat), longint'(m_sat[2]));
        end
    end

    task automatic cyc(bit we, logic [31:0] d, bit clr);
        write_en = we; din = d; clear = clr;
        @(posedge clk);
        model_step(we, clr, d);
        #1;
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; clear = 1'b0; din = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out",   longint'(a_out), 64'd0);
        chk("rst.done",  longint'(a_done), 64'd0);
        chk("rst.busy",  longint'(a_busy), 64'd0);
        chk("rst.count", longint'(a_count), 64'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1,2,3,4 back to back
        cyc(1'b1, 32'd1, 1'b0);
        chk("p1.count1", longint'(a_count), 64'd1);
        cyc(1'b1, 32'd2, 1'b0);
        cyc(1'b1, 32'd3, 1'b0);
        chk("p1.busy", longint'(a_busy), 64'd1);
        cyc(1'b1, 32'd4, 1'b0);
        chk("p1.out",  longint'(a_out), 64'd10);
        chk("p1.done", longint'(a_done), 64'd1);
        chk("p1.cnt0", longint'(a_count), 64'd0);
        chk("p1.c_out", longint'(c_out), 64'd4);
        cyc(1'b0, 32'd0, 1'b0);
        chk("p1.done_low", longint'(a_done), 64'd0);

        // -7 x4
        repeat (4) cyc(1'b1, 32'hFFFF_FFF9, 1'b0);
        chk("p2.out", longint'(a_out), 64'h0000_00FF_FFFF_FFE4);
        chk("p2.sat", longint'(a_sat), 64'd0);

        // clear mid-window, then gapped samples
        cyc(1'b1, 32'd5, 1'b0);
        cyc(1'b1, 32'd6, 1'b0);
        cyc(1'b0, 32'd0, 1'b1);
        chk("p3.clr_done", longint'(a_done), 64'd0);
        chk("p3.clr_out",  longint'(a_out), 64'h0000_00FF_FFFF_FFE4);
        chk("p3.clr_cnt",  longint'(a_count), 64'd0);
        cyc(1'b1, 32'd5, 1'b0); cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'd5, 1'b0); cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'd5, 1'b0);
        cyc(1'b1, 32'd5, 1'b0);
        chk("p3.out", longint'(a_out), 64'd20);

        // asynchronous reset between edges after two samples
        cyc(1'b1, 32'd1, 1'b0);
        cyc(1'b1, 32'd1, 1'b0);
        write_en = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("p4.out",   longint'(a_out), 64'd0);
        chk("p4.busy",  longint'(a_busy), 64'd0);
        chk("p4.count", longint'(a_count), 64'd0);
        #1 reset = 1'b0;
        repeat (4) cyc(1'b1, 32'd1, 1'b0);
        chk("p4.out4", longint'(a_out), 64'd4);

        // 32-bit accumulator with large positive samples
        repeat (4) cyc(1'b1, 32'h7FFF_FFFF, 1'b0);
`ifdef STD_WIN_ACC_SAT_EN
        chk("p5.out", longint'(b_out), 64'h7FFF_FFFF);
        chk("p5.sat", longint'(b_sat), 64'd1);
`else
        chk("p5.out", longint'(b_out), 64'hFFFF_FFFC);
        chk("p5.sat", longint'(b_sat), 64'd0);
`endif

        // COUNT=1 continuous, then clear+write_en
        cyc(1'b1, 32'd3, 1'b0);
        chk("p6.done1", longint'(c_done), 64'd1);
        chk("p6.out1",  longint'(c_out), 64'd3);
        cyc(1'b1, 32'd9, 1'b0);
        chk("p6.done2", longint'(c_done), 64'd1);
        chk("p6.out2",  longint'(c_out), 64'd9);
        cyc(1'b1, 32'd7, 1'b1);
        chk("p6.drop_done", longint'(c_done), 64'd0);
        chk("p6.drop_out",  longint'(c_out), 64'd9);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            bit          we, clr;
            case ($urandom_range(0, 5))
                0:       d = 32'h7FFF_FFFF;
                1:       d = 32'h8000_0000;
                2:       d = $urandom_range(0, 20) - 10;
                default: d = $urandom;
            endcase
            we  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 24) == 0);
            cyc(we, d, clr);
        end
        cyc(1'b0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
